// File: rtl/lidar_filter_pkg.sv
// Shared types and default widths for the lidar denoising path.
// The ROR neighbour counter and the distance calculator both size their buses from these.
package lidar_filter_pkg;

    localparam int DIST_W_DEF = 16;
    localparam int CNT_W_DEF  = 8;
    localparam int ID_W_DEF   = 16;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } ror_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Exposes the post-increment value so a caller can use this beat's count in the same cycle.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_next = count_q;
        if (inc && (count_q != '1)) begin
            count_next = count_q + 1'b1;
        end
        count_d = clear ? '0 : count_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ror_neighbor_counter.sv
// Radius-outlier-removal neighbour counter: counts in-radius distances per point
// and emits one keep/drop decision with the point tag when the set ends.
module ror_neighbor_counter
    import lidar_filter_pkg::*;
#(
    parameter int N            = DIST_W_DEF,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int ID_W         = ID_W_DEF,
    parameter int EXCLUDE_SELF = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N-1:0]     radius,
    input  logic [CNT_W-1:0] min_neighbors,
    input  logic [ID_W-1:0]  point_tag,
    input  logic             dist_valid,
    output logic             dist_ready,
    input  logic [N-1:0]     distance,
    input  logic             dist_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_keep,
    output logic [CNT_W-1:0] out_count,
    output logic [ID_W-1:0]  out_tag
);

    ror_state_t state_q, state_d;

    logic             first_q, first_d;
    logic             self_seen_q, self_seen_d;
    logic [N-1:0]     radius_q, radius_d;
    logic [CNT_W-1:0] min_q, min_d;
    logic [ID_W-1:0]  tag_q, tag_d;
    logic             out_keep_q, out_keep_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic [ID_W-1:0]  out_tag_q, out_tag_d;

    logic             beat_accept;
    logic             set_done;
    logic             self_beat;
    logic             hit;
    logic [N-1:0]     eff_radius;
    logic [CNT_W-1:0] eff_min;
    logic [ID_W-1:0]  eff_tag;
    logic [CNT_W-1:0] count_cur;
    logic [CNT_W-1:0] count_next;

    // The first beat of a set must compare against the live inputs, since they are only captured on that beat
    always_comb begin
        beat_accept = dist_valid && dist_ready;
        set_done    = beat_accept && dist_last;
        eff_radius  = first_q ? radius        : radius_q;
        eff_min     = first_q ? min_neighbors : min_q;
        eff_tag     = first_q ? point_tag     : tag_q;
        self_beat   = (EXCLUDE_SELF != 0) && (distance == '0) && !self_seen_q;
        hit         = beat_accept && (distance <= eff_radius) && !self_beat;
    end

    sat_counter #(
        .W(CNT_W)
    ) u_count (
        .clock      (clock),
        .reset      (reset),
        .clear      (set_done),
        .inc        (hit),
        .count      (count_cur),
        .count_next (count_next)
    );

    always_comb begin
        first_d     = first_q;
        self_seen_d = self_seen_q;
        radius_d    = radius_q;
        min_d       = min_q;
        tag_d       = tag_q;
        out_keep_d  = out_keep_q;
        out_count_d = out_count_q;
        out_tag_d   = out_tag_q;
        if (beat_accept) begin
            first_d = 1'b0;
            if (first_q) begin
                radius_d = radius;
                min_d    = min_neighbors;
                tag_d    = point_tag;
            end
            if (self_beat) begin
                self_seen_d = 1'b1;
            end
        end
        if (set_done) begin
            first_d     = 1'b1;
            self_seen_d = 1'b0;
            out_count_d = count_next;
            out_keep_d  = (count_next >= eff_min);
            out_tag_d   = eff_tag;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            first_q     <= 1'b1;
            self_seen_q <= 1'b0;
            radius_q    <= '0;
            min_q       <= '0;
            tag_q       <= '0;
            out_keep_q  <= 1'b0;
            out_count_q <= '0;
            out_tag_q   <= '0;
        end else begin
            first_q     <= first_d;
            self_seen_q <= self_seen_d;
            radius_q    <= radius_d;
            min_q       <= min_d;
            tag_q       <= tag_d;
            out_keep_q  <= out_keep_d;
            out_count_q <= out_count_d;
            out_tag_q   <= out_tag_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // HOLD refuses beats, which forces at least one idle cycle between consecutive sets
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACCUM:   if (set_done)  state_d = HOLD;
            HOLD:    if (out_ready) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_comb begin
        dist_ready = (state_q == ACCUM);
        out_valid  = (state_q == HOLD);
        out_keep   = out_keep_q;
        out_count  = out_count_q;
        out_tag    = out_tag_q;
    end

    logic unused_count;
    assign unused_count = ^count_cur;

endmodule

// File: tb/tb_ror_neighbor_counter.sv
// Scoreboard bench for ror_neighbor_counter: an 8-bit-count and a 4-bit-count instance
// share one stimulus stream; per-instance monitors pop expected decisions on each handshake.
module tb_ror_neighbor_counter;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] radius;
    logic [7:0]  min_neighbors;
    logic [15:0] point_tag;
    logic        dist_valid;
    logic [15:0] distance;
    logic        dist_last;
    logic        out_ready;

    logic        dist_ready8, out_valid8, out_keep8;
    logic [7:0]  out_count8;
    logic [15:0] out_tag8;
    logic        dist_ready4, out_valid4, out_keep4;
    logic [3:0]  out_count4;
    logic [15:0] out_tag4;

    typedef struct packed {
        logic [7:0]  count;
        logic        keep;
        logic [15:0] tag;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];
    int   beats[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clock = ~clock;

    ror_neighbor_counter #(.N(16), .CNT_W(8), .ID_W(16), .EXCLUDE_SELF(1)) dut8 (
        .clock(clock), .reset(reset), .radius(radius), .min_neighbors(min_neighbors),
        .point_tag(point_tag), .dist_valid(dist_valid), .dist_ready(dist_ready8),
        .distance(distance), .dist_last(dist_last), .out_valid(out_valid8),
        .out_ready(out_ready), .out_keep(out_keep8), .out_count(out_count8), .out_tag(out_tag8)
    );

    ror_neighbor_counter #(.N(16), .CNT_W(4), .ID_W(16), .EXCLUDE_SELF(1)) dut4 (
        .clock(clock), .reset(reset), .radius(radius), .min_neighbors(min_neighbors[3:0]),
        .point_tag(point_tag), .dist_valid(dist_valid), .dist_ready(dist_ready4),
        .distance(distance), .dist_last(dist_last), .out_valid(out_valid4),
        .out_ready(out_ready), .out_keep(out_keep4), .out_count(out_count4), .out_tag(out_tag4)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    always @(negedge clock) begin : mon8
        exp_t e;
        if (!reset && out_valid8 && out_ready) begin
            if (q8.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL dut8 unexpected decision: got count %0d tag %0d, expected none", out_count8, out_tag8);
            end else begin
                e = q8.pop_front();
                checkOutput("dut8 out_count", {24'd0, out_count8}, {24'd0, e.count});
                checkOutput("dut8 out_keep", {31'd0, out_keep8}, {31'd0, e.keep});
                checkOutput("dut8 out_tag", {16'd0, out_tag8}, {16'd0, e.tag});
            end
        end
    end

    always @(negedge clock) begin : mon4
        exp_t e;
        if (!reset && out_valid4 && out_ready) begin
            if (q4.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL dut4 unexpected decision: got count %0d tag %0d, expected none", out_count4, out_tag4);
            end else begin
                e = q4.pop_front();
                checkOutput("dut4 out_count", {28'd0, out_count4}, {24'd0, e.count});
                checkOutput("dut4 out_keep", {31'd0, out_keep4}, {31'd0, e.keep});
                checkOutput("dut4 out_tag", {16'd0, out_tag4}, {16'd0, e.tag});
            end
        end
    end

    // Streams the contents of beats[] as one set; late_change scrambles the sampled inputs after the first beat
    task automatic applyStimulus(input logic [15:0] r, input logic [7:0] m, input logic [15:0] tag,
                                 input int gap, input bit late_change,
                                 input logic [7:0] c8, input logic k8,
                                 input logic [7:0] c4, input logic k4);
        radius        = r;
        min_neighbors = m;
        point_tag     = tag;
        q8.push_back('{count: c8, keep: k8, tag: tag});
        q4.push_back('{count: c4, keep: k4, tag: tag});
        for (int i = 0; i < beats.size(); i++) begin
            dist_valid = 1'b1;
            distance   = beats[i][15:0];
            dist_last  = (i == beats.size() - 1);
            @(posedge clock);
            #1;
            dist_valid = 1'b0;
            dist_last  = 1'b0;
            if (late_change && i == 0) begin
                radius        = 16'd0;
                min_neighbors = 8'hff;
                point_tag     = 16'hffff;
            end
            if (i != beats.size() - 1) begin
                repeat (gap) begin
                    @(posedge clock);
                    #1;
                end
            end
        end
        checkOutput("latency out_valid dut8", {31'd0, out_valid8}, 32'd1);
        checkOutput("latency out_valid dut4", {31'd0, out_valid4}, 32'd1);
        checkOutput("hold dist_ready dut8", {31'd0, dist_ready8}, 32'd0);
        if (out_ready) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        reset         = 1'b1;
        radius        = '0;
        min_neighbors = '0;
        point_tag     = '0;
        dist_valid    = 1'b0;
        distance      = '0;
        dist_last     = 1'b0;
        out_ready     = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        checkOutput("reset out_valid", {31'd0, out_valid8}, 32'd0);
        checkOutput("reset dist_ready", {31'd0, dist_ready8}, 32'd1);
        checkOutput("reset out_keep", {31'd0, out_keep8}, 32'd0);
        checkOutput("reset out_count", {24'd0, out_count8}, 32'd0);
        checkOutput("reset out_tag", {16'd0, out_tag8}, 32'd0);
        checkOutput("reset out_valid dut4", {31'd0, out_valid4}, 32'd0);

        beats = '{0, 50, 100, 101};
        applyStimulus(16'd100, 8'd2, 16'd5, 0, 1'b0, 8'd2, 1'b1, 8'd2, 1'b1);
        applyStimulus(16'd100, 8'd3, 16'd6, 0, 1'b0, 8'd2, 1'b0, 8'd2, 1'b0);
        beats = '{500};
        applyStimulus(16'd100, 8'd0, 16'd7, 0, 1'b0, 8'd0, 1'b1, 8'd0, 1'b1);

        out_ready = 1'b0;
        beats = '{20, 200};
        applyStimulus(16'd100, 8'd1, 16'd9, 0, 1'b0, 8'd1, 1'b1, 8'd1, 1'b1);
        dist_valid = 1'b1;
        distance   = 16'd1;
        dist_last  = 1'b1;
        repeat (5) begin
            @(posedge clock);
            #1;
            checkOutput("bp dist_ready", {31'd0, dist_ready8}, 32'd0);
            checkOutput("bp out_valid", {31'd0, out_valid8}, 32'd1);
            checkOutput("bp out_count", {24'd0, out_count8}, 32'd1);
            checkOutput("bp out_tag", {16'd0, out_tag8}, 32'd9);
            checkOutput("bp out_keep", {31'd0, out_keep8}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        dist_valid = 1'b0;
        dist_last  = 1'b0;
        checkOutput("release out_valid", {31'd0, out_valid8}, 32'd0);
        checkOutput("release dist_ready", {31'd0, dist_ready8}, 32'd1);

        beats = '{0, 0, 0};
        applyStimulus(16'd10, 8'd2, 16'd11, 0, 1'b0, 8'd2, 1'b1, 8'd2, 1'b1);
        beats = '{0, 5, 7};
        applyStimulus(16'd10, 8'd2, 16'd12, 0, 1'b1, 8'd2, 1'b1, 8'd2, 1'b1);

        beats.delete();
        for (int i = 0; i < 20; i++) beats.push_back(10);
        applyStimulus(16'd10, 8'd15, 16'd13, 3, 1'b0, 8'd20, 1'b1, 8'd15, 1'b1);

        radius        = 16'd10;
        min_neighbors = 8'd2;
        point_tag     = 16'd20;
        for (int i = 0; i < 3; i++) begin
            dist_valid = 1'b1;
            distance   = 16'd5;
            dist_last  = 1'b0;
            @(posedge clock);
            #1;
        end
        dist_valid = 1'b0;
        reset      = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        checkOutput("midset reset out_valid", {31'd0, out_valid8}, 32'd0);
        checkOutput("midset reset dist_ready", {31'd0, dist_ready8}, 32'd1);
        beats = '{5, 5};
        applyStimulus(16'd10, 8'd2, 16'd14, 0, 1'b0, 8'd2, 1'b1, 8'd2, 1'b1);

        repeat (3) @(posedge clock);
        #1;
        checkOutput("dut8 decisions outstanding", q8.size(), 32'd0);
        checkOutput("dut4 decisions outstanding", q4.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
